// File: rtl/data_mem_responder_pkg.sv
// data_mem_responder_pkg: FSM encoding, word width and wait-counter sizing
// shared by the data-memory responder and its RAM.
package data_mem_responder_pkg;
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } state_e;
    localparam int WORD_W          = 32;
    localparam int DEF_WAIT_CYCLES = 2;
    localparam int CNT_W           = 4;
endpackage

// File: rtl/data_mem_responder_word_ram_sp.sv
// data_mem_responder_word_ram_sp: single-port synchronous word RAM, one write or
// one registered read per clock; the array has no reset.
module data_mem_responder_word_ram_sp #(
    parameter int ADDR_W = 8,
    parameter int WORD_W = 32
) (
    input  logic              clk,
    input  logic              we,
    input  logic              re,
    input  logic [ADDR_W-1:0] addr,
    input  logic [WORD_W-1:0] wdata,
    output logic [WORD_W-1:0] rdata
);
    logic [WORD_W-1:0] mem [2**ADDR_W];
    logic [WORD_W-1:0] rdata_q;

    always_ff @(posedge clk) begin
        if (we) mem[addr] <= wdata;
        if (re) rdata_q <= mem[addr];
    end

    assign rdata = rdata_q;
endmodule

// File: rtl/data_mem_responder.sv
// data_mem_responder: fixed-latency load/store responder for the datapath memory port.
// Define MISALIGN_TRAP_EN to flag and suppress accesses with req_addr[1:0] != 0.
module data_mem_responder
    import data_mem_responder_pkg::*;
#(
    parameter int ADDR_W      = 8,
    parameter int WAIT_CYCLES = DEF_WAIT_CYCLES
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req_valid,
    input  logic              req_write,
    input  logic [31:0]       req_addr,
    input  logic [WORD_W-1:0] req_wdata,
    output logic              req_ready,
    output logic              resp_valid,
    output logic [WORD_W-1:0] resp_rdata,
    output logic              resp_err,
    output logic              stall
);
    state_e            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              write_q, write_d;
    logic [ADDR_W+1:0] addr_q, addr_d;
    logic [WORD_W-1:0] wdata_q, wdata_d;
    logic [WORD_W-1:0] rdata_q, rdata_d;
    logic [WORD_W-1:0] ram_rdata;
    logic              access, mis, load_ok;
    logic              unused_bits;

`ifdef MISALIGN_TRAP_EN
    assign mis = |addr_q[1:0];
`else
    assign mis = 1'b0;
`endif

    assign load_ok     = ~write_q & ~mis;
    assign req_ready   = state_q == IDLE;
    assign resp_valid  = state_q == RESP;
    assign resp_err    = resp_valid & mis;
    assign stall       = req_valid & ~resp_valid;
    assign unused_bits = ^{req_addr[31:ADDR_W+2], addr_q[1:0]};
    // The RAM's read register carries fresh load data only during RESP; rdata_q keeps it afterwards.
    assign resp_rdata  = (resp_valid && load_ok) ? ram_rdata : rdata_q;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        write_d = write_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        rdata_d = rdata_q;
        access  = 1'b0;
        case (state_q)
            IDLE: if (req_valid) begin
                state_d = WAIT;
                cnt_d   = CNT_W'(WAIT_CYCLES);
                write_d = req_write;
                addr_d  = req_addr[ADDR_W+1:0];
                wdata_d = req_wdata;
            end
            WAIT: if (cnt_q == '0) begin
                access  = 1'b1;
                state_d = RESP;
            end else begin
                cnt_d = cnt_q - 1'b1;
            end
            RESP: begin
                state_d = IDLE;
                if (load_ok) rdata_d = ram_rdata;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            write_q <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            write_q <= write_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            rdata_q <= rdata_d;
        end
    end

    data_mem_responder_word_ram_sp #(
        .ADDR_W(ADDR_W),
        .WORD_W(WORD_W)
    ) u_ram (
        .clk  (clk),
        .we   (access & write_q & ~mis),
        .re   (access & load_ok),
        .addr (addr_q[ADDR_W+1:2]),
        .wdata(wdata_q),
        .rdata(ram_rdata)
    );
endmodule

// File: tb/tb_data_mem_responder.sv
// tb_data_mem_responder: randomized load/store traffic against a word-array
// reference model, with a queue-based scoreboard checked by a separate monitor.
module tb_data_mem_responder;
    localparam int ADDR_W = 8;
    localparam int W      = 2;

    logic        clk = 0, reset = 0, req_valid = 0, req_write = 0;
    logic [31:0] req_addr = 0, req_wdata = 0;
    logic        req_ready, resp_valid, resp_err, stall;
    logic [31:0] resp_rdata;

    always #5 clk = ~clk;

    data_mem_responder #(.ADDR_W(ADDR_W), .WAIT_CYCLES(W)) dut (
        .clk(clk), .reset(reset), .req_valid(req_valid), .req_write(req_write),
        .req_addr(req_addr), .req_wdata(req_wdata), .req_ready(req_ready),
        .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_err(resp_err),
        .stall(stall)
    );

    typedef struct {
        int          acc;
        bit          has_data;
        logic [31:0] data;
        bit          err;
    } exp_t;

    exp_t        q[$];
    logic [31:0] mdl[int];
    logic [31:0] last_rdata = 0;
    int          cyc = 0, checks = 0, fails = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor: response due exactly W+1 cycles after acceptance; ready only when nothing is outstanding.
    always @(negedge clk) begin
        bit   due;
        exp_t e;
        if (!reset) begin
            q.delete();
            last_rdata = 0;
        end
        due = q.size() > 0 && (cyc - q[0].acc == W + 1);
        check("resp_valid", resp_valid, due);
        check("req_ready", req_ready, q.size() == 0);
        check("stall", stall, req_valid && !due);
        if (due) begin
            e = q.pop_front();
            if (e.has_data) last_rdata = e.data;
            check("resp_err", resp_err, e.err);
        end
        check("resp_rdata", resp_rdata, last_rdata);
    end

    task automatic do_req(input bit w, input logic [31:0] a, input logic [31:0] d);
        int   n, idx;
        bit   trap;
        exp_t e;
        req_valid = 1; req_write = w; req_addr = a; req_wdata = d;
        n = 0;
        while (!req_ready && n < 50) begin @(posedge clk); #1; n++; end
        checks++;
        if (!req_ready) begin
            fails++;
            $display("FAIL accept_timeout: req_ready=0 expected 1 within 50 cycles");
            req_valid = 0;
            return;
        end
        @(posedge clk); #1;
        idx  = int'(a >> 2) % (1 << ADDR_W);
        trap = 0;
`ifdef MISALIGN_TRAP_EN
        trap = (a % 4) != 0;
`endif
        e.acc      = cyc;
        e.err      = trap;
        e.has_data = !w && !trap;
        e.data     = e.has_data ? mdl[idx] : 32'h0;
        if (w && !trap) mdl[idx] = d;
        q.push_back(e);
        n = 0;
        do begin @(posedge clk); #1; n++; end while (!resp_valid && n < 50);
        checks++;
        if (!resp_valid) begin
            fails++;
            $display("FAIL resp_timeout: resp_valid=0 expected 1 within 50 cycles");
        end
        @(posedge clk); #1;
    endtask

    task automatic idle(input int n);
        req_valid = 0;
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Store accepted, then reset pulled during its wait phase: must neither write nor respond.
    task automatic abort_store(input logic [31:0] a, input logic [31:0] d);
        req_valid = 1; req_write = 1; req_addr = a; req_wdata = d;
        checks++;
        if (!req_ready) begin
            fails++;
            $display("FAIL abort_ready: req_ready=0 expected 1");
        end
        @(posedge clk); #1;
        reset = 0; req_valid = 0;
        repeat (W + 3) @(posedge clk);
        #1;
        reset = 1;
        @(posedge clk); #1;
    endtask

    initial begin
        logic [31:0] a;
        int          idx, off;
        reset = 0;
        repeat (3) @(posedge clk);
        #1;
        reset = 1;
        @(posedge clk); #1;
        for (int i = 0; i < 16; i++) do_req(1, 32'(i * 4), $urandom);
        do_req(1, 32'h10, 32'hCAFEF00D);
        do_req(0, 32'h10, 0);
        idle(2);
        do_req(1, 32'h400, 32'h11);
        do_req(0, 32'h0, 0);
        abort_store(32'h20, 32'hAA);
        do_req(0, 32'h20, 0);
        do_req(1, 32'h22, 32'h1234_5678);
        do_req(0, 32'h20, 0);
        do_req(0, 32'h0, 0);
        do_req(0, 32'h4, 0);
        idle(1);
        for (int i = 0; i < 200; i++) begin
            idx = $urandom_range(0, 15);
            off = ($urandom_range(0, 7) == 0) ? $urandom_range(1, 3) : 0;
            a   = ($urandom & 32'hFFFF_FC00) | 32'(idx << 2) | 32'(off);
            do_req($urandom_range(0, 1) == 1, a, $urandom);
            if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 3));
        end
        idle(3);
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end
endmodule
